ahb_rf_rd_bridge: RTL and testbench

//  AHB-Lite slave giving a debug host read access to the integer register file.

---
 rtl/ahb_rf_pkg.sv | 29 ++
 rtl/ahb_rf_addr_dec.sv | 25 ++
 rtl/ahb_rf_rd_bridge.sv | 104 ++++++++++
 tb/tb_ahb_rf_rd_bridge.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_rf_pkg.sv
// rtl/ahb_rf_pkg.sv - shared AHB encodings, offsets, FSM state and decode types for the RF debug read bridge
package ahb_rf_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [7:0] OFS_ID     = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  typedef struct packed {
    logic       is_err;
    logic       is_id;
    logic [4:0] index;
  } dec_t;

endpackage

// File: rtl/ahb_rf_addr_dec.sv
// rtl/ahb_rf_addr_dec.sv - address-phase decode to {is_err, is_id, index}; AHB_RF_WR_ERR_EN makes writes error
module ahb_rf_addr_dec
  import ahb_rf_pkg::*;
(
  input  logic [7:0] addr,
  input  logic [2:0] size,
  input  logic       write,
  output dec_t       dec
);

  logic bad;

  assign bad = (addr[1:0] != 2'b00) || (size != HSIZE_WORD) || (addr > OFS_ID);

`ifdef AHB_RF_WR_ERR_EN
  assign dec.is_err = bad | write;
`else
  // Writes are silently accepted, so their shape is never an error.
  assign dec.is_err = bad & ~write;
`endif

  assign dec.is_id = (addr == OFS_ID);
  assign dec.index = addr[6:2];

endmodule

// File: rtl/ahb_rf_rd_bridge.sv
// rtl/ahb_rf_rd_bridge.sv - AHB-Lite slave for debug reads of the integer RF
// Optional feature macro: AHB_RF_WR_ERR_EN (accepted writes get a two-cycle ERROR response).
module ahb_rf_rd_bridge
  import ahb_rf_pkg::*;
#(
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h5246_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic [4:0]  ahb_rf_addr,
  input  logic [31:0] ahb_rf_data
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      state;
  state_t      state_nx;
  dec_t        dec;
  logic [3:0]  cnt;
  logic        is_id_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        start_rd;
  logic        unused_ok;

  assign unused_ok = ^{haddr[31:8], hwdata};
  assign accept    = hsel & htrans[1] & hready;

  ahb_rf_addr_dec u_dec (
    .addr  (haddr[7:0]),
    .size  (hsize),
    .write (hwrite),
    .dec   (dec)
  );

  always_comb begin
    state_nx  = state;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    start_rd  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (state == ST_ERR2) hresp = HRESP_ERROR;
        if (accept) begin
          if (dec.is_err) begin
            state_nx = ST_ERR1;
          end else if (hwrite) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_RD;
            start_rd = 1'b1;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RD: begin
        hreadyout = 1'b0;
        if (cnt == 4'd0) state_nx = ST_DONE;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_nx  = ST_ERR2;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      is_id_q     <= 1'b0;
      rdata_q     <= 32'd0;
      ahb_rf_addr <= 5'd0;
    end else begin
      state <= state_nx;
      if (start_rd) begin
        ahb_rf_addr <= dec.index;
        cnt         <= WS;
        is_id_q     <= dec.is_id;
      end else if (state == ST_RD) begin
        // RF is sampled only in the final RD cycle.
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else             rdata_q <= is_id_q ? ID_VALUE : ahb_rf_data;
      end
    end
  end

  assign hrdata = (state == ST_DONE) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_ahb_rf_rd_bridge.sv
// tb/tb_ahb_rf_rd_bridge.sv - directed table-driven bench for ahb_rf_rd_bridge (WAIT_STATES 0, 3 and 5)
module tb_ahb_rf_rd_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready;
  logic [31:0] hwdata;
  logic [2:0]  hro;
  logic [2:0]  hrsp;
  logic [31:0] hrd [3];
  logic [4:0]  rfa [3];
  logic [31:0] rfd [3];
  logic [31:0] rf  [32];

  int checks   = 0;
  int failures = 0;

`ifdef AHB_RF_WR_ERR_EN
  localparam int   WR_LOWS = 1;
  localparam logic WR_RESP = 1'b1;
`else
  localparam int   WR_LOWS = 0;
  localparam logic WR_RESP = 1'b0;
`endif

  always #5 clk = ~clk;

  assign rfd[0] = rf[rfa[0]];
  assign rfd[1] = rf[rfa[1]];
  assign rfd[2] = rf[rfa[2]];

  ahb_rf_rd_bridge #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hready(hready), .hwdata(hwdata), .hreadyout(hro[0]), .hresp(hrsp[0]),
    .hrdata(hrd[0]), .ahb_rf_addr(rfa[0]), .ahb_rf_data(rfd[0]));

  ahb_rf_rd_bridge #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hready(hready), .hwdata(hwdata), .hreadyout(hro[1]), .hresp(hrsp[1]),
    .hrdata(hrd[1]), .ahb_rf_addr(rfa[1]), .ahb_rf_data(rfd[1]));

  ahb_rf_rd_bridge #(.WAIT_STATES(5)) u5 (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hready(hready), .hwdata(hwdata), .hreadyout(hro[2]), .hresp(hrsp[2]),
    .hrdata(hrd[2]), .ahb_rf_addr(rfa[2]), .ahb_rf_data(rfd[2]));

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    int          lows;
    logic        resp;
    logic [31:0] data;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'b010;
    hready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = s;
    hready = 1'b1;
  endtask

  // One transfer on instance u; counts stall cycles and samples the final data-phase cycle.
  task automatic xfer(input int u, input string name, input logic [31:0] a, input logic w,
                      input logic [2:0] s, input logic exp_err,
                      output int lows, output logic resp, output logic [31:0] data);
    @(negedge clk);
    addr_phase(a, w, s);
    @(negedge clk);
    bus_idle();
    lows = 0;
    while (hro[u] == 1'b0 && lows < 40) begin
      chk({name, "_hrdata_stall"}, hrd[u], 32'd0);
      chk({name, "_hresp_stall"}, {31'd0, hrsp[u]}, {31'd0, exp_err});
      lows++;
      @(negedge clk);
    end
    if (lows >= 40) chk({name, "_timeout"}, 32'd1, 32'd0);
    resp = hrsp[u];
    data = hrd[u];
  endtask

  initial begin
    int          lows;
    logic        resp;
    logic [31:0] data;

    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    rf[1] = 32'd1;
    rf[2] = 32'd2;
    rf[5] = 32'hDEAD_BEEF;
    haddr  = 32'd0;
    hwdata = 32'hCAFE_F00D;
    bus_idle();
    rst = 1'b1;

    vt[0] = '{"rd_r5",      32'h0000_0014, 1'b0, 3'b010, 1,       1'b0,    32'hDEAD_BEEF};
    vt[1] = '{"rd_id",      32'h0000_0080, 1'b0, 3'b010, 1,       1'b0,    32'h5246_0001};
    vt[2] = '{"rd_r31",     32'h0000_007C, 1'b0, 3'b010, 1,       1'b0,    32'h1000_001F};
    vt[3] = '{"rd_r0",      32'h0000_0000, 1'b0, 3'b010, 1,       1'b0,    32'h1000_0000};
    vt[4] = '{"rd_hi_bits", 32'hFFFF_FF14, 1'b0, 3'b010, 1,       1'b0,    32'hDEAD_BEEF};
    vt[5] = '{"err_84",     32'h0000_0084, 1'b0, 3'b010, 1,       1'b1,    32'd0};
    vt[6] = '{"err_06",     32'h0000_0006, 1'b0, 3'b010, 1,       1'b1,    32'd0};
    vt[7] = '{"err_half",   32'h0000_0010, 1'b0, 3'b001, 1,       1'b1,    32'd0};
    vt[8] = '{"err_fc",     32'h0000_00FC, 1'b0, 3'b010, 1,       1'b1,    32'd0};
    vt[9] = '{"wr_10",      32'h0000_0010, 1'b1, 3'b010, WR_LOWS, WR_RESP, 32'd0};

    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst_hreadyout%0d", u), {31'd0, hro[u]}, 32'd1);
      chk($sformatf("rst_hresp%0d", u), {31'd0, hrsp[u]}, 32'd0);
      chk($sformatf("rst_hrdata%0d", u), hrd[u], 32'd0);
      chk($sformatf("rst_rfaddr%0d", u), {27'd0, rfa[u]}, 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      xfer(0, vt[i].name, vt[i].addr, vt[i].wr, vt[i].size, vt[i].resp, lows, resp, data);
      chk({vt[i].name, "_lows"}, lows, vt[i].lows);
      chk({vt[i].name, "_resp"}, {31'd0, resp}, {31'd0, vt[i].resp});
      chk({vt[i].name, "_data"}, data, vt[i].data);
    end

    // Read of r5 with cycle-exact checks, then a write must leave ahb_rf_addr alone.
    do_reset();
    @(negedge clk);
    addr_phase(32'h14, 1'b0, 3'b010);
    @(negedge clk);
    bus_idle();
    chk("t1_rfaddr_t1", {27'd0, rfa[0]}, 32'd5);
    chk("t1_hreadyout_t1", {31'd0, hro[0]}, 32'd0);
    @(negedge clk);
    chk("t1_hreadyout_t2", {31'd0, hro[0]}, 32'd1);
    chk("t1_hresp_t2", {31'd0, hrsp[0]}, 32'd0);
    chk("t1_hrdata_t2", hrd[0], 32'hDEAD_BEEF);
    xfer(0, "t5_wr", 32'h10, 1'b1, 3'b010, WR_RESP, lows, resp, data);
    chk("t5_wr_lows", lows, WR_LOWS);
    chk("t5_wr_resp", {31'd0, resp}, {31'd0, WR_RESP});
    chk("t5_rfaddr_kept", {27'd0, rfa[0]}, 32'd5);

    // ID read with three wait states.
    do_reset();
    xfer(1, "t2_id_ws3", 32'h80, 1'b0, 3'b010, 1'b0, lows, resp, data);
    chk("t2_lows", lows, 4);
    chk("t2_resp", {31'd0, resp}, 32'd0);
    chk("t2_data", data, 32'h5246_0001);

    // Back-to-back: second NONSEQ is pending during RD and taken in the DONE cycle.
    do_reset();
    @(negedge clk);
    addr_phase(32'h04, 1'b0, 3'b010);
    @(negedge clk);
    addr_phase(32'h08, 1'b0, 3'b010);
    hready = 1'b0;
    chk("t3_rd1_hreadyout", {31'd0, hro[0]}, 32'd0);
    @(negedge clk);
    hready = 1'b1;
    chk("t3_done1_hreadyout", {31'd0, hro[0]}, 32'd1);
    chk("t3_done1_data", hrd[0], 32'd1);
    @(negedge clk);
    bus_idle();
    chk("t3_rd2_hreadyout", {31'd0, hro[0]}, 32'd0);
    chk("t3_rd2_rfaddr", {27'd0, rfa[0]}, 32'd2);
    @(negedge clk);
    chk("t3_done2_hreadyout", {31'd0, hro[0]}, 32'd1);
    chk("t3_done2_data", hrd[0], 32'd2);

    // Asynchronous reset in the middle of a WAIT_STATES=5 read.
    do_reset();
    @(negedge clk);
    addr_phase(32'h14, 1'b0, 3'b010);
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    chk("t6_pre_hreadyout", {31'd0, hro[2]}, 32'd0);
    chk("t6_pre_rfaddr", {27'd0, rfa[2]}, 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_hreadyout", {31'd0, hro[2]}, 32'd1);
    chk("t6_rst_hresp", {31'd0, hrsp[2]}, 32'd0);
    chk("t6_rst_hrdata", hrd[2], 32'd0);
    chk("t6_rst_rfaddr", {27'd0, rfa[2]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xfer(2, "t6_after", 32'h14, 1'b0, 3'b010, 1'b0, lows, resp, data);
    chk("t6_after_lows", lows, 6);
    chk("t6_after_resp", {31'd0, resp}, 32'd0);
    chk("t6_after_data", data, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
